// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - pointer, accept, occupancy and flag control for uart_fifo (no data path)
module uart_fifo_ctrl #(
  parameter int ADDR_W             = 8,
  parameter int ALMOST_FULL_LEVEL  = (1 << ADDR_W) - 4,
  parameter int ALMOST_EMPTY_LEVEL = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              wr_accept,
  output logic              rd_accept,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] wr_ptr_n, rd_ptr_n, count_n;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
  always_comb begin
    rd_accept = rd_en & ~empty & ~clear;
    wr_accept = wr_en & (~full | rd_accept) & ~clear;
    wr_ptr_n  = wr_ptr;
    rd_ptr_n  = rd_ptr;
    if (clear) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
    end else begin
      if (wr_accept) wr_ptr_n = wr_ptr + 1'b1;
      if (rd_accept) rd_ptr_n = rd_ptr + 1'b1;
    end
    count_n = wr_ptr_n - rd_ptr_n;
  end

  assign wr_addr = wr_ptr[ADDR_W-1:0];
  assign rd_addr = rd_ptr[ADDR_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      count        <= count_n;
      full         <= (wr_ptr_n[ADDR_W] != rd_ptr_n[ADDR_W]) &&
                      (wr_ptr_n[ADDR_W-1:0] == rd_ptr_n[ADDR_W-1:0]);
      empty        <= (wr_ptr_n == rd_ptr_n);
      almost_full  <= (count_n >= (ADDR_W+1)'(ALMOST_FULL_LEVEL));
      almost_empty <= (count_n <= (ADDR_W+1)'(ALMOST_EMPTY_LEVEL));
      if (clear) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_en && !wr_accept) overflow  <= 1'b1;
        if (rd_en && !rd_accept) underflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous UART data FIFO with standard or first-word-fall-through read
module uart_fifo #(
  parameter int DATA_BIT                 = 8,
  parameter int DATA_BUFFER_LENGTH_WIDTH = 8,
  parameter int ALMOST_FULL_LEVEL        = (1 << DATA_BUFFER_LENGTH_WIDTH) - 4,
  parameter int ALMOST_EMPTY_LEVEL       = 4,
  parameter bit FWFT                     = 1'b0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              clear,
  input  logic                              wr_en,
  input  logic [DATA_BIT-1:0]               wr_data,
  input  logic                              rd_en,
  output logic [DATA_BIT-1:0]               rd_data,
  output logic                              rd_valid,
  output logic                              full,
  output logic                              empty,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic [DATA_BUFFER_LENGTH_WIDTH:0] count,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int W     = DATA_BUFFER_LENGTH_WIDTH;
  localparam int DEPTH = 1 << W;

  if (ALMOST_FULL_LEVEL < 0 || ALMOST_FULL_LEVEL > DEPTH ||
      ALMOST_EMPTY_LEVEL < 0 || ALMOST_EMPTY_LEVEL > DEPTH) begin : g_bad_level
    $error("uart_fifo: almost-full/almost-empty level outside 0..DEPTH");
  end

  logic         wr_accept, rd_accept;
  logic [W-1:0] wr_addr, rd_addr;

  uart_fifo_ctrl #(
    .ADDR_W             (W),
    .ALMOST_FULL_LEVEL  (ALMOST_FULL_LEVEL),
    .ALMOST_EMPTY_LEVEL (ALMOST_EMPTY_LEVEL)
  ) u_ctrl (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .wr_accept    (wr_accept),
    .rd_accept    (rd_accept),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  logic [DATA_BIT-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_addr] <= wr_data;
  end

  if (FWFT) begin : g_fwft
    // Masked while empty so the uninitialised array never leaks onto rd_data.
    assign rd_valid = ~empty;
    assign rd_data  = rd_valid ? mem[rd_addr] : '0;
  end else begin : g_std
    logic [DATA_BIT-1:0] rd_data_q;
    logic                rd_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_accept;
        if (rd_accept) rd_data_q <= mem[rd_addr];
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_uart_fifo.sv
// tb/tb_uart_fifo.sv - scoreboard bench for uart_fifo, standard and FWFT instances at DEPTH=16
module tb_uart_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic       s_reset_n, s_clear, s_wr_en, s_rd_en;
  logic [7:0] s_wr_data, s_rd_data;
  logic       s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [4:0] s_count;

  logic       f_reset_n, f_clear, f_wr_en, f_rd_en;
  logic [7:0] f_wr_data, f_rd_data;
  logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] f_count;

  uart_fifo #(.DATA_BIT(8), .DATA_BUFFER_LENGTH_WIDTH(4), .FWFT(1'b0)) u_std (
    .clk(clk), .reset_n(s_reset_n), .clear(s_clear), .wr_en(s_wr_en), .wr_data(s_wr_data),
    .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  uart_fifo #(.DATA_BIT(8), .DATA_BUFFER_LENGTH_WIDTH(4), .FWFT(1'b1)) u_fwft (
    .clk(clk), .reset_n(f_reset_n), .clear(f_clear), .wr_en(f_wr_en), .wr_data(f_wr_data),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  logic [7:0] s_exp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s_write(input logic [7:0] d);
    s_wr_en = 1'b1; s_wr_data = d;
    tick();
    s_wr_en = 1'b0;
  endtask

  task automatic s_read(input logic [7:0] exp);
    s_exp.push_back(exp);
    s_rd_en = 1'b1;
    tick();
    s_rd_en = 1'b0;
  endtask

  // Monitor: every rd_valid pulse from the standard instance must match the next queued word.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (s_rd_valid === 1'b1) begin
        vectors++;
        if (s_exp.size() == 0) begin
          miscompares++;
          $display("FAIL std_unexpected_valid: got rd_data 0x%0h with no read pending", s_rd_data);
        end else begin
          e = s_exp.pop_front();
          if (s_rd_data !== e) begin
            miscompares++;
            $display("FAIL std_rd_data: got 0x%0h, expected 0x%0h", s_rd_data, e);
          end
        end
      end
    end
  end

  initial begin
    s_reset_n = 1'b0; s_clear = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0; s_wr_data = '0;
    f_reset_n = 1'b0; f_clear = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;
    tick(); tick();

    check("rst_empty", s_empty, 1);
    check("rst_full", s_full, 0);
    check("rst_count", s_count, 0);
    check("rst_rd_valid", s_rd_valid, 0);
    check("rst_rd_data", s_rd_data, 0);
    check("rst_almost_empty", s_ae, 1);
    check("rst_almost_full", s_af, 0);
    check("rst_overflow", s_ovf, 0);
    check("rst_underflow", s_unf, 0);
    s_reset_n = 1'b1;
    f_reset_n = 1'b1;
    tick();

    // Basic write 4 / read 4
    for (int i = 1; i <= 4; i++) s_write(8'(i));
    check("t1_count4", s_count, 4);
    check("t1_almost_empty4", s_ae, 1);
    for (int i = 1; i <= 4; i++) s_read(8'(i));
    tick();
    check("t1_empty", s_empty, 1);
    check("t1_count0", s_count, 0);

    // Fill to DEPTH, then overflow
    for (int i = 0; i < 16; i++) begin
      s_write(8'h10 + 8'(i));
      if (i == 4)  check("t2_almost_empty5", s_ae, 0);
      if (i == 10) check("t2_almost_full11", s_af, 0);
      if (i == 11) check("t2_almost_full12", s_af, 1);
    end
    check("t2_full", s_full, 1);
    check("t2_count16", s_count, 16);
    s_write(8'hEE);
    check("t2_overflow", s_ovf, 1);
    check("t2_count_hold", s_count, 16);

    s_clear = 1'b1; tick(); s_clear = 1'b0;
    check("clr_count", s_count, 0);
    check("clr_empty", s_empty, 1);
    check("clr_full", s_full, 0);
    check("clr_overflow", s_ovf, 0);
    check("clr_rd_data_hold", s_rd_data, 8'h04);
    check("clr_rd_valid", s_rd_valid, 0);

    // Simultaneous read/write on full
    for (int i = 0; i < 16; i++) s_write(8'h20 + 8'(i));
    s_exp.push_back(8'h20);
    s_wr_en = 1'b1; s_wr_data = 8'hAA; s_rd_en = 1'b1;
    tick();
    s_wr_en = 1'b0; s_rd_en = 1'b0;
    check("t3_count16", s_count, 16);
    check("t3_full", s_full, 1);
    check("t3_no_overflow", s_ovf, 0);
    for (int i = 1; i < 16; i++) s_read(8'h20 + 8'(i));
    s_read(8'hAA);
    tick();
    check("t3_empty", s_empty, 1);

    // Underflow, then simultaneous read/write on empty
    s_rd_en = 1'b1; tick(); s_rd_en = 1'b0;
    check("t4_underflow", s_unf, 1);
    check("t4_rd_valid", s_rd_valid, 0);
    s_rd_en = 1'b1; s_wr_en = 1'b1; s_wr_data = 8'h55;
    tick();
    s_rd_en = 1'b0; s_wr_en = 1'b0;
    check("t4_underflow_sticky", s_unf, 1);
    check("t4_count1", s_count, 1);
    check("t4_rd_valid_rej", s_rd_valid, 0);
    s_read(8'h55);
    tick();

    // Wrap-around: three rounds of 12 in / 12 out
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) s_write(8'h40 + 8'(r * 16 + i));
      check("t5_count12", s_count, 12);
      for (int i = 0; i < 12; i++) s_read(8'h40 + 8'(r * 16 + i));
    end
    tick();
    check("t5_count0", s_count, 0);
    check("t5_empty", s_empty, 1);

    // FWFT instance
    f_wr_en = 1'b1; f_wr_data = 8'h3C; tick(); f_wr_en = 1'b0;
    check("fw_rd_valid", f_rd_valid, 1);
    check("fw_rd_data", f_rd_data, 8'h3C);
    f_rd_en = 1'b1; tick(); f_rd_en = 1'b0;
    check("fw_empty", f_empty, 1);
    check("fw_rd_valid0", f_rd_valid, 0);
    f_rd_en = 1'b1; tick(); f_rd_en = 1'b0;
    check("fw_underflow", f_unf, 1);
    for (int i = 0; i < 5; i++) begin
      f_wr_en = 1'b1; f_wr_data = 8'h61 + 8'(i); tick();
    end
    f_wr_en = 1'b0;
    check("fw_count5", f_count, 5);
    check("fw_head", f_rd_data, 8'h61);
    f_rd_en = 1'b1; tick(); f_rd_en = 1'b0;
    check("fw_head2", f_rd_data, 8'h62);
    f_clear = 1'b1; tick(); f_clear = 1'b0;
    check("fw_clr_count", f_count, 0);
    check("fw_clr_empty", f_empty, 1);
    check("fw_clr_rd_valid", f_rd_valid, 0);
    check("fw_clr_underflow", f_unf, 0);

    // Reset mid-burst
    f_wr_en = 1'b1; f_wr_data = 8'h71; tick();
    f_wr_data = 8'h72; tick();
    f_reset_n = 1'b0;
    #1;
    check("fw_mrst_count", f_count, 0);
    check("fw_mrst_empty", f_empty, 1);
    check("fw_mrst_rd_valid", f_rd_valid, 0);
    check("fw_mrst_rd_data", f_rd_data, 0);
    check("fw_mrst_almost_empty", f_ae, 1);
    f_wr_en = 1'b0;

    begin
      int waited = 0;
      while (s_exp.size() != 0 && waited < 20) begin
        tick();
        waited++;
      end
      vectors++;
      if (s_exp.size() != 0) begin
        miscompares++;
        $display("FAIL std_drain: %0d reads never returned, expected 0", s_exp.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
